serial_chain_io: RTL and testbench

SERIAL_CHAIN_IO -- requirements
Module: serial_chain_io

---
 rtl/serial_chain_io.sv | 118 +++++++++++
 tb/tb_serial_chain_io.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_chain_io.sv
// Drives a 74HC595 output chain and reads a 74HC165 input chain over one shared serial clock.
// Frame = (WIDTH+2)*2*DIV clk cycles; start is ignored while busy, and rx_data/done follow the latch period.
module serial_chain_io #(
  parameter int WIDTH = 16,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             auto_refresh,
  input  logic [WIDTH-1:0] tx_data,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             done,
  output logic             ser_clk,
  output logic             ser_out,
  input  logic             ser_in,
  output logic             load_n,
  output logic             latch
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

  state_t           state, state_nxt;
  logic [DW-1:0]    div_cnt;
  logic             half;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] capture;
  logic             period_end;
  logic             sample;

  // half=0 is the low half of a bit period, half=1 the high half
  assign period_end = half && (div_cnt == DIV_LAST);
  assign sample     = (state == SHIFT) && half && (div_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    ser_clk   = 1'b0;
    ser_out   = 1'b0;
    load_n    = 1'b1;
    latch     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start || auto_refresh) state_nxt = LOAD;
      end
      LOAD: begin
        load_n = 1'b0;
        if (period_end) state_nxt = SHIFT;
      end
      SHIFT: begin
        ser_clk = half;
        ser_out = shadow[WIDTH-1];
        if (period_end && (bit_cnt == BIT_LAST)) state_nxt = LATCH;
      end
      LATCH: begin
        latch   = 1'b1;
        ser_out = shadow[WIDTH-1];
        if (period_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt  <= '0;
      half     <= 1'b0;
      bit_cnt  <= '0;
      shadow   <= '0;
      capture  <= '0;
      rx_data  <= '0;
      done     <= 1'b0;
      rx_valid <= 1'b0;
    end else begin
      done     <= 1'b0;
      rx_valid <= 1'b0;
      if (state == IDLE) begin
        div_cnt <= '0;
        half    <= 1'b0;
        bit_cnt <= '0;
        if (start || auto_refresh) shadow <= tx_data;
      end else begin
        if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
          half    <= ~half;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
        if (sample) capture <= (capture << 1) | WIDTH'(ser_in);
        // the last bit is not shifted away so ser_out holds it through LATCH
        if ((state == SHIFT) && period_end && (bit_cnt != BIT_LAST)) begin
          shadow  <= shadow << 1;
          bit_cnt <= bit_cnt + 1'b1;
        end
        if ((state == LATCH) && period_end) begin
          rx_data  <= capture;
          done     <= 1'b1;
          rx_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_chain_io.sv
// Bench for serial_chain_io: a 74HC165 input-chain model plus scoreboards for shifted bits and captured words.
module tb_serial_chain_io;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, auto_refresh;
  logic [15:0] tx_data, rx_data;
  logic        rx_valid, busy, done, ser_clk, ser_out, ser_in, load_n, latch;

  logic        start1, ser_in1;
  logic [0:0]  tx1, rx1;
  logic        rx_valid1, busy1, done1, ser_clk1, ser_out1, load_n1, latch1;

  serial_chain_io #(.WIDTH(16), .DIV(2)) dut (
    .clk(clk), .reset(reset), .start(start), .auto_refresh(auto_refresh),
    .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .done(done), .ser_clk(ser_clk), .ser_out(ser_out), .ser_in(ser_in),
    .load_n(load_n), .latch(latch)
  );

  serial_chain_io #(.WIDTH(1), .DIV(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .auto_refresh(1'b0),
    .tx_data(tx1), .rx_data(rx1), .rx_valid(rx_valid1), .busy(busy1),
    .done(done1), .ser_clk(ser_clk1), .ser_out(ser_out1), .ser_in(ser_in1),
    .load_n(load_n1), .latch(latch1)
  );

  int          checks = 0;
  int          errors = 0;
  logic        bit_q[$];
  logic [15:0] rx_q[$];
  logic        sb_on = 1'b1;
  logic [15:0] chain = '0;
  logic [15:0] rx_pattern = '0;
  logic        sclk_d = 1'b0;

  assign ser_in = chain[15];

  // input chain shifts after each serial-clock fall; scoreboards pop on ser_clk rise and rx_valid
  always @(negedge clk) begin
    logic        eb;
    logic [15:0] ew;
    if (!load_n) chain <= rx_pattern;
    else if (!ser_clk && sclk_d) chain <= chain << 1;
    if (sb_on && ser_clk && !sclk_d) begin
      checks++;
      if (bit_q.size() == 0) begin
        errors++;
        $display("FAIL ser_out_extra: got bit %0b with none expected", ser_out);
      end else begin
        eb = bit_q.pop_front();
        if (ser_out !== eb) begin
          errors++;
          $display("FAIL ser_out_bit: got %0b expected %0b", ser_out, eb);
        end
      end
    end
    if (sb_on && rx_valid) begin
      checks++;
      if (rx_q.size() == 0) begin
        errors++;
        $display("FAIL rx_extra: got rx_data %h with none expected", rx_data);
      end else begin
        ew = rx_q.pop_front();
        if (rx_data !== ew || done !== 1'b1) begin
          errors++;
          $display("FAIL rx_word: got %h done=%0b expected %h done=1", rx_data, done, ew);
        end
      end
    end
    sclk_d <= ser_clk;
  end

  task automatic push_tx(input logic [15:0] v);
    for (int i = 15; i >= 0; i--) bit_q.push_back(v[i]);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; auto_refresh = 1'b0; tx_data = '0;
    start1 = 1'b0; tx1 = 1'b0; ser_in1 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ser_clk, ser_out, load_n, latch, busy, done, rx_valid} !== 7'b0010000 || rx_data !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %b rx=%h expected 0010000 rx=0000",
               {ser_clk, ser_out, load_n, latch, busy, done, rx_valid}, rx_data);
    end
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_autostart: got busy=%0b busy1=%0b expected 0 0", busy, busy1);
    end
  endtask

  task automatic test_single_frame();
    int   lo_cnt = 0, lo_last = -1, lat_cnt = 0, lat_first = -1, done_n = -1;
    logic busy0 = 1'b0, busy_at_done = 1'b1, rxv_at_done = 1'b0;
    tx_data = 16'h2BD7; rx_pattern = 16'hA5C3;
    push_tx(16'h2BD7); rx_q.push_back(16'hA5C3);
    pulse_start();
    for (int n = 0; n < 90; n++) begin
      if (n > 0) @(negedge clk);
      if (n == 0) busy0 = busy;
      if (!load_n) begin lo_cnt++; lo_last = n; end
      if (latch) begin if (lat_first < 0) lat_first = n; lat_cnt++; end
      if (done && done_n < 0) begin done_n = n; busy_at_done = busy; rxv_at_done = rx_valid; end
    end
    checks++;
    if (busy0 !== 1'b1) begin errors++; $display("FAIL busy_after_accept: got %0b expected 1", busy0); end
    checks++;
    if (lo_cnt != 4 || lo_last != 3) begin
      errors++; $display("FAIL load_n_window: got %0d cycles ending %0d expected 4 ending 3", lo_cnt, lo_last);
    end
    checks++;
    if (lat_cnt != 4 || lat_first != 68) begin
      errors++; $display("FAIL latch_window: got %0d cycles from %0d expected 4 from 68", lat_cnt, lat_first);
    end
    checks++;
    if (done_n != 72) begin errors++; $display("FAIL done_time: got %0d expected 72", done_n); end
    checks++;
    if (busy_at_done !== 1'b0 || rxv_at_done !== 1'b1) begin
      errors++; $display("FAIL done_coincident: got busy=%0b rx_valid=%0b expected 0 1", busy_at_done, rxv_at_done);
    end
    checks++;
    if (bit_q.size() != 0 || rx_data !== 16'hA5C3) begin
      errors++; $display("FAIL frame_complete: got %0d bits left rx=%h expected 0 left rx=a5c3", bit_q.size(), rx_data);
    end
  endtask

  task automatic test_ignore_start();
    int          done_cnt = 0, busy_rises = 0;
    logic        bprev = 1'b1;
    logic [15:0] rx_mid = '0;
    tx_data = 16'h2BD7; rx_pattern = 16'h0F0F;
    push_tx(16'h2BD7); rx_q.push_back(16'h0F0F);
    pulse_start();
    for (int n = 0; n < 200; n++) begin
      if (n > 0) @(negedge clk);
      if (n == 10) tx_data = 16'hFFFF;
      if (n == 30) start = 1'b1;
      if (n == 31) start = 1'b0;
      if (n == 40) rx_mid = rx_data;
      if (done) done_cnt++;
      if (busy && !bprev) busy_rises++;
      bprev = busy;
    end
    checks++;
    if (done_cnt != 1 || busy_rises != 0) begin
      errors++; $display("FAIL start_while_busy: got %0d done %0d restarts expected 1 0", done_cnt, busy_rises);
    end
    checks++;
    if (rx_mid !== 16'hA5C3) begin errors++; $display("FAIL rx_hold_midframe: got %h expected a5c3", rx_mid); end
    checks++;
    if (bit_q.size() != 0 || rx_data !== 16'h0F0F) begin
      errors++; $display("FAIL shadow_frame: got %0d bits left rx=%h expected 0 left rx=0f0f", bit_q.size(), rx_data);
    end
  endtask

  task automatic test_auto_refresh();
    int   started = 0, d = 0;
    int   t[3];
    logic bprev = 1'b0;
    rx_pattern = 16'h5A5A;
    push_tx(16'h0001); push_tx(16'h0002); push_tx(16'h0003);
    repeat (3) rx_q.push_back(16'h5A5A);
    tx_data = 16'h0001;
    @(negedge clk) auto_refresh = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (busy && !bprev) begin
        started++;
        if (started == 1) tx_data = 16'h0002;
        else if (started == 2) tx_data = 16'h0003;
        else begin auto_refresh = 1'b0; tx_data = 16'h0000; end
      end
      if (done) begin if (d < 3) t[d] = n; d++; end
      bprev = busy;
    end
    auto_refresh = 1'b0;
    checks++;
    if (d != 3 || started != 3) begin
      errors++; $display("FAIL auto_frames: got %0d done %0d starts expected 3 3", d, started);
    end else begin
      checks++;
      if (t[1] - t[0] != 73 || t[2] - t[1] != 73) begin
        errors++; $display("FAIL auto_spacing: got %0d %0d expected 73 73", t[1] - t[0], t[2] - t[1]);
      end
    end
    checks++;
    if (busy !== 1'b0 || bit_q.size() != 0 || rx_q.size() != 0) begin
      errors++; $display("FAIL auto_stop: got busy=%0b bits=%0d words=%0d expected 0 0 0", busy, bit_q.size(), rx_q.size());
    end
  endtask

  task automatic test_reset_midframe();
    int done_cnt = 0;
    sb_on = 1'b0;
    tx_data = 16'h1234;
    pulse_start();
    repeat (40) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({ser_clk, ser_out, load_n, latch, busy, done, rx_valid} !== 7'b0010000 || rx_data !== 16'h0) begin
      errors++;
      $display("FAIL reset_async: got %b rx=%h expected 0010000 rx=0000",
               {ser_clk, ser_out, load_n, latch, busy, done, rx_valid}, rx_data);
    end
    @(negedge clk) reset = 1'b0;
    for (int n = 0; n < 150; n++) begin
      @(negedge clk);
      if (done || rx_valid || busy) done_cnt++;
    end
    checks++;
    if (done_cnt != 0 || rx_data !== 16'h0) begin
      errors++; $display("FAIL reset_abort: got %0d active cycles rx=%h expected 0 rx=0000", done_cnt, rx_data);
    end
    bit_q.delete();
    sb_on = 1'b1;
  endtask

  task automatic test_width1();
    int   done_n = -1;
    logic sout = 1'b0, rxv = 1'b0;
    tx1 = 1'b1; ser_in1 = 1'b1;
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    for (int n = 0; n < 16; n++) begin
      if (n > 0) @(negedge clk);
      if (ser_clk1) sout = ser_out1;
      if (done1 && done_n < 0) begin done_n = n; rxv = rx_valid1; end
    end
    checks++;
    if (done_n != 6 || rxv !== 1'b1) begin
      errors++; $display("FAIL w1_timing: got done at %0d rx_valid=%0b expected 6 1", done_n, rxv);
    end
    checks++;
    if (rx1 !== 1'b1 || sout !== 1'b1) begin
      errors++; $display("FAIL w1_data: got rx=%0b ser_out=%0b expected 1 1", rx1, sout);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_frame();
    test_ignore_start();
    test_auto_refresh();
    test_reset_midframe();
    test_width1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
